// File: rtl/logical_ops.sv
// rtl/logical_ops.sv - registered 4-operand logical-operator unit, 1-bit result one cycle after in_valid
// Optional: define LOGICAL_OPS_EXT_EN to implement ops 4-7 (EQ, NONE, MAJ, MIX); otherwise they yield 0.
module logical_ops #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   input  logic [W-1:0] d,
   output logic         x,
   output logic         out_valid
);

   logic ta, tb, tc, td;
   logic result;

   assign ta = |a;
   assign tb = |b;
   assign tc = |c;
   assign td = |d;

   always_comb begin
      result = 1'b0;
      case (op)
         3'd0: result = ta & tb & tc & td;
         3'd1: result = ta | tb | tc | td;
         3'd2: result = (ta & tb) | (tc & td);
         3'd3: result = ta ^ tb ^ tc ^ td;
`ifdef LOGICAL_OPS_EXT_EN
         // EQ compares full operand values, not their truth values
         3'd4: result = (a == b) && (c == d);
         3'd5: result = ~(ta | tb | tc | td);
         3'd6: result = (ta & tb & tc) | (ta & tb & td) | (ta & tc & td) | (tb & tc & td);
         3'd7: result = (ta & ~tb) | (tc & ~td);
`endif
         default: result = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x         <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            x <= result;
         end
      end
   end

endmodule

// File: tb/tb_logical_ops.sv
// tb/tb_logical_ops.sv - table-driven self-checking bench for logical_ops
module tb_logical_ops;

   typedef struct {
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] c;
      logic [3:0] d;
      logic       x;
   } vec_t;

`ifdef LOGICAL_OPS_EXT_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [2:0] op;
   logic [3:0] a, b, c, d;
   logic       x;
   logic       out_valid;

   int tests  = 0;
   int errors = 0;

   vec_t vecs[$];

   logical_ops #(.W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .op        (op),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
      .x         (x),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] o,
                        input logic [3:0] ia, input logic [3:0] ib,
                        input logic [3:0] ic, input logic [3:0] id);
      in_valid = v;
      op       = o;
      a        = ia;
      b        = ib;
      c        = ic;
      d        = id;
   endtask

   initial begin
      // All-true operands, op sweep 0..7 back-to-back
      vecs.push_back('{3'd0, 4'h1, 4'hA, 4'hC, 4'h2, 1'b1});
      vecs.push_back('{3'd1, 4'h1, 4'hA, 4'hC, 4'h2, 1'b1});
      vecs.push_back('{3'd2, 4'h1, 4'hA, 4'hC, 4'h2, 1'b1});
      vecs.push_back('{3'd3, 4'h1, 4'hA, 4'hC, 4'h2, 1'b0});
      vecs.push_back('{3'd4, 4'h1, 4'hA, 4'hC, 4'h2, 1'b0});
      vecs.push_back('{3'd5, 4'h1, 4'hA, 4'hC, 4'h2, 1'b0});
      vecs.push_back('{3'd6, 4'h1, 4'hA, 4'hC, 4'h2, 1'b1});
      vecs.push_back('{3'd7, 4'h1, 4'hA, 4'hC, 4'h2, 1'b0});
      // All-zero operands
      vecs.push_back('{3'd5, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1});
      vecs.push_back('{3'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0});
      vecs.push_back('{3'd4, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1});
      vecs.push_back('{3'd1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0});
      // Mixed a=3 b=0 c=0 d=7
      vecs.push_back('{3'd7, 4'h3, 4'h0, 4'h0, 4'h7, 1'b1});
      vecs.push_back('{3'd2, 4'h3, 4'h0, 4'h0, 4'h7, 1'b0});
      vecs.push_back('{3'd3, 4'h3, 4'h0, 4'h0, 4'h7, 1'b0});
      vecs.push_back('{3'd6, 4'h3, 4'h0, 4'h0, 4'h7, 1'b0});
      // Further directed cases
      vecs.push_back('{3'd3, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1});
      vecs.push_back('{3'd4, 4'h5, 4'h5, 4'h2, 4'h2, 1'b1});
      vecs.push_back('{3'd4, 4'h5, 4'h5, 4'h2, 4'h3, 1'b0});
      vecs.push_back('{3'd2, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1});
      vecs.push_back('{3'd7, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1});
      vecs.push_back('{3'd6, 4'h1, 4'h1, 4'h1, 4'h0, 1'b1});
      vecs.push_back('{3'd1, 4'h0, 4'h0, 4'h0, 4'h8, 1'b1});
      vecs.push_back('{3'd0, 4'hF, 4'h8, 4'h4, 4'h0, 1'b0});

      // Reset held 2 cycles against an active request
      rst = 1'b1;
      drive(1'b1, 3'd1, 4'h1, 4'h2, 4'h3, 4'h4);
      repeat (2) begin
         @(negedge clk);
         check("reset x", x, 1'b0);
         check("reset out_valid", out_valid, 1'b0);
      end
      rst = 1'b0;
      drive(1'b0, 3'd1, 4'h1, 4'h2, 4'h3, 4'h4);
      @(negedge clk);
      check("post-reset x", x, 1'b0);
      check("post-reset out_valid", out_valid, 1'b0);

      // Table sweep, one request per cycle
      for (int i = 0; i < vecs.size(); i++) begin
         logic exp;
         exp = (!EXT && vecs[i].op >= 3'd4) ? 1'b0 : vecs[i].x;
         drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
         @(negedge clk);
         check($sformatf("vec%0d op%0d x", i, vecs[i].op), x, exp);
         check($sformatf("vec%0d op%0d out_valid", i, vecs[i].op), out_valid, 1'b1);
      end

      // Hold: result persists while in_valid is low and operands change
      drive(1'b1, 3'd1, 4'h1, 4'h0, 4'h0, 4'h0);
      @(negedge clk);
      check("hold setup x", x, 1'b1);
      drive(1'b0, 3'd1, 4'h0, 4'h0, 4'h0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("hold%0d x", i), x, 1'b1);
         check($sformatf("hold%0d out_valid", i), out_valid, 1'b0);
      end

      // Reset mid-stream drops the request in flight
      rst = 1'b1;
      drive(1'b1, 3'd1, 4'h1, 4'h1, 4'h1, 4'h1);
      @(negedge clk);
      check("midreset x", x, 1'b0);
      check("midreset out_valid", out_valid, 1'b0);
      rst = 1'b0;
      drive(1'b0, 3'd1, 4'h1, 4'h1, 4'h1, 4'h1);
      @(negedge clk);
      check("after midreset x", x, 1'b0);
      check("after midreset out_valid", out_valid, 1'b0);

      // Ext-only op with all operands true: MAJ=1 when enabled, 0 otherwise
      drive(1'b1, 3'd6, 4'h2, 4'h3, 4'h4, 4'h5);
      @(negedge clk);
      check("config op6 x", x, EXT ? 1'b1 : 1'b0);
      check("config op6 out_valid", out_valid, 1'b1);
      drive(1'b0, 3'd0, 4'h0, 4'h0, 4'h0, 4'h0);
      @(negedge clk);
      check("config idle out_valid", out_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
